// File: rtl/fb_scanout.sv
// Raster-order frame-buffer reader emitting a tagged RGB pixel stream, one frame per start pulse.
// Latency: first pixel valid 3 cycles after start is sampled; 1 pixel/cycle sustained.
// Backpressure: 2-entry output buffer, reads throttled so buffer + in-flight never exceeds 2.
module fb_scanout #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic              fb_re,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } pix_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              inflight;
    logic [2:0]        inflight_tags;
    pix_t              head, skid, new_pix;
    logic              skid_vld;
    logic              accept;
    logic [1:0]        occ_sum;
    logic              room;
    logic              iss_sof, iss_eol, iss_eof;

    assign accept  = pix_valid & pix_ready;
    // A pixel leaving this cycle frees its slot for a read issued in the same cycle.
    assign occ_sum = 2'(pix_valid) + 2'(skid_vld) + 2'(inflight);
    assign room    = occ_sum < (2'd2 + 2'(accept));

    assign iss_sof = (fb_addr == '0);
    assign iss_eol = (col == LAST_COL);
    assign iss_eof = iss_eol && (row == LAST_ROW);

    assign done      = (state == IDLE);
    assign pix_data  = head.data;
    assign pix_sof   = head.sof;
    assign pix_eol   = head.eol;
    assign pix_eof   = head.eof;
    assign new_pix   = '{data: fb_rdata, sof: inflight_tags[2], eol: inflight_tags[1], eof: inflight_tags[0]};

    always_comb begin
        state_nxt = state;
        fb_re     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                fb_re = room;
                if (room && fb_addr == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: if (accept && head.eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fb_addr       <= '0;
            col           <= '0;
            row           <= '0;
            inflight      <= 1'b0;
            inflight_tags <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fb_re;
            if (fb_re) begin
                inflight_tags <= {iss_sof, iss_eol, iss_eof};
                fb_addr       <= (fb_addr == LAST_ADDR) ? '0 : fb_addr + 1'b1;
                col           <= iss_eol ? '0 : col + 1'b1;
                if (iss_eol) row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end
        end
    end

    // Head register drives the outputs; skid holds the second pixel while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            skid      <= '0;
            pix_valid <= 1'b0;
            skid_vld  <= 1'b0;
        end else begin
            case ({inflight, accept})
                2'b10: begin
                    if (!pix_valid) begin
                        head      <= new_pix;
                        pix_valid <= 1'b1;
                    end else begin
                        skid     <= new_pix;
                        skid_vld <= 1'b1;
                    end
                end
                2'b01: begin
                    if (skid_vld) begin
                        head     <= skid;
                        skid_vld <= 1'b0;
                    end else begin
                        pix_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (skid_vld) begin
                        head <= skid;
                        skid <= new_pix;
                    end else begin
                        head <= new_pix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on an 8x4 frame: expected pixels queued at start, popped on accept.
module tb_fb_scanout;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;
    localparam int AW = 17;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic          fb_re;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_rdata = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [DW-1:0] pix_data;
    logic          pix_sof, pix_eol, pix_eof;

    int checks = 0;
    int errors = 0;

    logic [DW+2:0] sb[$];
    int issued = 0;
    int accepted = 0;
    int exp_addr = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW+2:0] exp_v, got_v;

    fb_scanout #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .fb_re(fb_re), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    always #5 clk = ~clk;

    // Frame-buffer model: pixel value equals its address, one cycle after the read.
    always @(posedge clk) if (fb_re) fb_rdata <= DW'(fb_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int a = 0; a < N; a++)
            sb.push_back({DW'(a), a == 0, (a % H) == H - 1, a == N - 1});
    endtask

    task automatic do_start();
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            issued     = 0;
            accepted   = 0;
            exp_addr   = 0;
            prev_stall = 1'b0;
        end else begin
            if (fb_re) begin
                chk("fb_addr_order", 32'(fb_addr), 32'(exp_addr));
                exp_addr = (exp_addr == N - 1) ? 0 : exp_addr + 1;
                issued++;
            end
            if (prev_stall) begin
                chk("stall_valid", {31'd0, pix_valid}, 32'd1);
                chk("stall_data", 32'(pix_data), 32'(prev_data));
            end
            if (pix_valid && pix_ready) begin
                accepted++;
                got_v = {pix_data, pix_sof, pix_eol, pix_eof};
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", 32'(got_v), 32'hFFFF_FFFF);
                end else begin
                    exp_v = sb.pop_front();
                    chk("pixel", 32'(got_v), 32'(exp_v));
                end
            end
            if (fb_re || (pix_valid && pix_ready))
                chk("outstanding_le2", {31'd0, (issued - accepted) <= 2}, 32'd1);
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rdy_pat;
        int base;
        rdy_pat = 16'b1001_0110_1100_1011;

        // Reset state
        #12;
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_fb_re", {31'd0, fb_re}, 32'd0);
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_data", 32'(pix_data), 32'd0);
        chk("rst_tags", {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Frame 1: ready held high, check latency and frame length
        pix_ready = 1'b1;
        do_start();
        chk("c1_fb_re", {31'd0, fb_re}, 32'd1);
        chk("c1_addr", 32'(fb_addr), 32'd0);
        chk("c1_done", {31'd0, done}, 32'd0);
        tick();
        chk("c2_valid", {31'd0, pix_valid}, 32'd0);
        tick();
        chk("c3_valid", {31'd0, pix_valid}, 32'd1);
        chk("c3_sof", {31'd0, pix_sof}, 32'd1);
        chk("c3_data", 32'(pix_data), 32'd0);
        for (int i = 3; i < N + 2; i++) tick();
        chk("cN2_done", {31'd0, done}, 32'd0);
        tick();
        chk("cN3_done", {31'd0, done}, 32'd1);
        chk("f1_drained", 32'(sb.size()), 32'd0);

        // Frame 2: pseudo-random ready pattern, extra start mid-frame must be ignored
        do_start();
        for (int i = 0; i < 600; i++) begin
            pix_ready = rdy_pat[i % 16];
            start = (i == 10);
            tick();
            if (done) break;
        end
        start = 1'b0;
        pix_ready = 1'b1;
        chk("f2_done", {31'd0, done}, 32'd1);
        chk("f2_addr_wrap", 32'(fb_addr), 32'd0);
        chk("f2_drained", 32'(sb.size()), 32'd0);
        tick();
        tick();
        chk("f2_no_restart", {31'd0, done}, 32'd1);

        // Frame 3: ready low from start, exactly two reads then hold
        pix_ready = 1'b0;
        base = issued;
        do_start();
        for (int i = 0; i < 5; i++) tick();
        chk("stall_reads", 32'(issued - base), 32'd2);
        chk("stall_fb_re", {31'd0, fb_re}, 32'd0);
        chk("stall_hold_valid", {31'd0, pix_valid}, 32'd1);
        chk("stall_hold_data", 32'(pix_data), 32'd0);
        pix_ready = 1'b1;
        wait_done("f3_done");
        chk("f3_drained", 32'(sb.size()), 32'd0);

        // Frame 4: asynchronous reset mid-frame, then a clean rescan
        do_start();
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, pix_valid}, 32'd0);
        chk("arst_fb_re", {31'd0, fb_re}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd1);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        tick();
        tick();
        chk("f5_valid", {31'd0, pix_valid}, 32'd1);
        chk("f5_data", 32'(pix_data), 32'd0);
        chk("f5_sof", {31'd0, pix_sof}, 32'd1);
        wait_done("f5_done");
        chk("f5_drained", 32'(sb.size()), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
